// File: rtl/serial_packet_ctrl.sv
// Packet framer between the serial byte receiver and the frame-memory write port.
// Hunts for SYNC, captures CMD and a 16-bit length, streams payload to memory, then verifies the checksum.
module serial_packet_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2400000
) (
  input  logic                  clk_24,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [7:0]            cmd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CSUM
  } state_t;

  state_t      state;
  logic [7:0]  checksum;
  logic [15:0] length;
  logic [23:0] tcnt;

  // Timeout fires on the idle cycle that would bring the gap counter to TIMEOUT_CYCLES
  logic timeout_c;
  assign timeout_c = (state != IDLE) && !rx_valid && (tcnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk_24) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      cmd       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      checksum  <= 8'd0;
      length    <= 16'd0;
      tcnt      <= 24'd0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      if (mem_we) mem_addr <= mem_addr + ADDR_WIDTH'(1);

      if (state == IDLE || rx_valid) tcnt <= 24'd0;
      else                           tcnt <= tcnt + 24'd1;

      if (timeout_c) begin
        state    <= IDLE;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= 2'd2;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= CMD;
              busy  <= 1'b1;
            end
          end
          CMD: begin
            cmd      <= rx_data;
            checksum <= rx_data;
            mem_addr <= '0;
            state    <= LEN_HI;
          end
          LEN_HI: begin
            length[15:8] <= rx_data;
            checksum     <= checksum + rx_data;
            state        <= LEN_LO;
          end
          LEN_LO: begin
            length[7:0] <= rx_data;
            checksum    <= checksum + rx_data;
            state       <= ({length[15:8], rx_data} == 16'd0) ? CSUM : PAYLOAD;
          end
          PAYLOAD: begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_data;
            checksum  <= checksum + rx_data;
            length    <= length - 16'd1;
            if (length == 16'd1) state <= CSUM;
          end
          CSUM: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_data == checksum) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_packet_ctrl.sv
// Scoreboard bench for serial_packet_ctrl: expected writes and done/err events are queued
// as packets are sent and matched when the DUT produces them.
module tb_serial_packet_ctrl;

  localparam int unsigned AW = 16;

  logic          clk_24;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    cmd;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  serial_packet_ctrl #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(24'd200)
  ) dut (
    .clk_24   (clk_24),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cmd      (cmd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  int total = 0;
  int bad   = 0;

  logic [AW+7:0] wq[$];
  logic [1:0]    evq[$];   // 0 = done, 1 = checksum error, 2 = timeout
  logic          rxv_d = 1'b0;
  logic [7:0]    pkt[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wq.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_24);
    #1 rx_valid = 1'b0;
    @(posedge clk_24);
    #1;
  endtask

  task automatic send_seq(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
    check({tag, "_evq_empty"}, 32'(evq.size()), 32'd0);
  endtask

  always @(posedge clk_24) rxv_d <= rx_valid;

  // Output monitor: matches writes and done/err pulses against the scoreboard
  always @(negedge clk_24) begin
    if (!reset) begin
      if (mem_we) begin
        logic [AW+7:0] e;
        check("we_one_cycle_after_rx", 32'(rxv_d), 32'd1);
        if (wq.size() == 0) begin
          check("unexpected_write", 32'(mem_we), 32'd0);
        end else begin
          e = wq.pop_front();
          check("we_addr", 32'(mem_addr), 32'(e[AW+7:8]));
          check("we_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
      if (done || err) begin
        check("done_err_exclusive", 32'(done & err), 32'd0);
        if (evq.size() == 0) begin
          check("unexpected_event", {30'd0, done, err}, 32'd0);
        end else begin
          logic [1:0] ev;
          ev = evq.pop_front();
          check("event_kind", 32'(done ? 2'd0 : err_code), 32'(ev));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    reset    = 1'b1;
    repeat (3) @(posedge clk_24);
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk_24);
    #1;

    // Three-byte packet, good checksum
    push_wr(16'd0, 8'h10); push_wr(16'd1, 8'h20); push_wr(16'd2, 8'h30);
    evq.push_back(2'd0);
    send_byte(8'hA5);
    check("t1_busy_after_sync", 32'(busy), 32'd1);
    pkt = '{8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    send_seq(pkt);
    check_drained("t1");
    check("t1_cmd", 32'(cmd), 32'h01);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Zero-length packet
    evq.push_back(2'd0);
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02};
    send_seq(pkt);
    check_drained("t2");
    check("t2_cmd", 32'(cmd), 32'h02);

    // Bad checksum: writes still land
    push_wr(16'd0, 8'hAA); push_wr(16'd1, 8'hBB);
    evq.push_back(2'd1);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_seq(pkt);
    check_drained("t3");
    check("t3_busy_low", 32'(busy), 32'd0);
    check("t3_err_code_held", 32'(err_code), 32'd1);

    // Inter-byte timeout, then recovery
    push_wr(16'd0, 8'h11);
    evq.push_back(2'd2);
    pkt = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h11};
    send_seq(pkt);
    check("t4_busy_waiting", 32'(busy), 32'd1);
    for (int i = 0; i < 400 && evq.size() != 0; i++) @(posedge clk_24);
    #1;
    check_drained("t4");
    check("t4_busy_low", 32'(busy), 32'd0);
    check("t4_err_code", 32'(err_code), 32'd2);
    push_wr(16'd0, 8'h7F);
    evq.push_back(2'd0);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h7F, 8'h81};
    send_seq(pkt);
    check_drained("t4b");

    // Noise before sync, SYNC value inside payload is data
    push_wr(16'd0, 8'hA5);
    evq.push_back(2'd0);
    pkt = '{8'h00, 8'hFF};
    send_seq(pkt);
    check("t5_busy_noise", 32'(busy), 32'd0);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hA5, 8'hA7};
    send_seq(pkt);
    check_drained("t5");

    // Reset mid-packet
    push_wr(16'd0, 8'h01); push_wr(16'd1, 8'h02);
    pkt = '{8'hA5, 8'h04, 8'h00, 8'h04, 8'h01, 8'h02};
    send_seq(pkt);
    reset = 1'b1;
    @(posedge clk_24);
    #1;
    check("t6_rst_mem_we", 32'(mem_we), 32'd0);
    check("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("t6_rst_cmd", 32'(cmd), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    pkt = '{8'h03, 8'h04};
    send_seq(pkt);
    repeat (5) @(posedge clk_24);
    #1;
    check_drained("t6");
    push_wr(16'd0, 8'hC0); push_wr(16'd1, 8'hDE);
    evq.push_back(2'd0);
    pkt = '{8'hA5, 8'h05, 8'h00, 8'h02, 8'hC0, 8'hDE, 8'hA5};
    send_seq(pkt);
    check_drained("t6b");
    check("t6b_cmd", 32'(cmd), 32'h05);

    repeat (3) @(posedge clk_24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
